dist_writeback_unit: RTL and testbench

Write-direction counterpart of the distribution load path. It accepts a 256-bit distribution word from the core together with a target address in rs1. It stalls the pipeline while it serialises one SPI write frame to the external distribution store: command, 24-bit address, 256-bit payload MSB first, and an optional CRC byte. It then releases the stall with a one-cycle completion pulse.

---
 rtl/dist_writeback_unit_if.sv | 22 ++
 rtl/dist_writeback_unit.sv | 188 ++++++++++++++++++
 tb/tb_dist_writeback_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dist_writeback_unit_if.sv
// Core-side write request and SPI pins of the distribution write-back unit.
// master: core/bench side, slave: dist_writeback_unit.
interface dist_writeback_unit_if;
  logic         DUWrCtrl;
  logic [31:0]  rs1;
  logic [255:0] DU_data;
  logic         du_wr_stall;
  logic         du_wr_done;
  logic         spi_cs_n;
  logic         spi_sck;
  logic         spi_mosi;

  modport master (
    output DUWrCtrl, rs1, DU_data,
    input  du_wr_stall, du_wr_done, spi_cs_n, spi_sck, spi_mosi
  );

  modport slave (
    input  DUWrCtrl, rs1, DU_data,
    output du_wr_stall, du_wr_done, spi_cs_n, spi_sck, spi_mosi
  );
endinterface

// File: rtl/dist_writeback_unit.sv
// Serialises {CMD_WRITE, rs1[23:0], DU_data} into one SPI mode-0 write frame while stalling the core.
// Defining DU_WR_CRC_EN appends a serial CRC-8 (poly 0x07) byte to the frame.
module dist_writeback_unit #(
  parameter int         CLK_DIV   = 4,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dist_writeback_unit_if.slave bus
);

`ifdef DU_WR_CRC_EN
  localparam int FRAME_W = 296;
`else
  localparam int FRAME_W = 288;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [8:0] BIT_LAST = 9'(FRAME_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [FRAME_W-1:0]   shift_r, shift_s;
  logic [7:0]           div_cnt_r, div_cnt_s;
  logic [8:0]           bit_cnt_r, bit_cnt_s;
  logic                 sck_r, sck_s;
  logic                 cs_n_r, cs_n_s;
  logic                 mosi_r, mosi_s;
  logic                 stall_r, stall_s;
  logic                 done_r, done_s;
  logic                 div_term_s;

`ifdef DU_WR_CRC_EN
  localparam logic [8:0] PAY_LAST = 9'd287;

  logic [7:0] crc_r, crc_s;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  assign div_term_s = (div_cnt_r == DIV_LAST);

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    sck_s     = sck_r;
    cs_n_s    = cs_n_r;
    mosi_s    = mosi_r;
    stall_s   = stall_r;
    done_s    = 1'b0;
`ifdef DU_WR_CRC_EN
    crc_s     = crc_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.DUWrCtrl) begin
          state_s   = ST_SHIFT;
`ifdef DU_WR_CRC_EN
          shift_s   = {CMD_WRITE, bus.rs1[23:0], bus.DU_data, 8'h00};
          crc_s     = 8'h00;
`else
          shift_s   = {CMD_WRITE, bus.rs1[23:0], bus.DU_data};
`endif
          div_cnt_s = 8'd0;
          bit_cnt_s = 9'd0;
          sck_s     = 1'b0;
          cs_n_s    = 1'b0;
          mosi_s    = CMD_WRITE[7];
          stall_s   = 1'b1;
        end else begin
          cs_n_s  = 1'b1;
          sck_s   = 1'b0;
          mosi_s  = 1'b0;
          stall_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_term_s) begin
          div_cnt_s = 8'd0;
          if (!sck_r) begin
            sck_s = 1'b1;
          end else begin
            // Falling SCK: advance to the next bit so MOSI is settled long before the next rise.
            sck_s     = 1'b0;
            bit_cnt_s = bit_cnt_r + 9'd1;
`ifdef DU_WR_CRC_EN
            if (bit_cnt_r <= PAY_LAST) begin
              crc_s = crc8_step(crc_r, shift_r[FRAME_W-1]);
            end else begin
              crc_s = crc_r;
            end
            if (bit_cnt_r == PAY_LAST) begin
              shift_s = {crc_s, {(FRAME_W-8){1'b0}}};
            end else begin
              shift_s = {shift_r[FRAME_W-2:0], 1'b0};
            end
`else
            shift_s = {shift_r[FRAME_W-2:0], 1'b0};
`endif
            mosi_s = shift_s[FRAME_W-1];
            if (bit_cnt_r == BIT_LAST) begin
              state_s = ST_HOLD;
            end else begin
              state_s = ST_SHIFT;
            end
          end
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      ST_HOLD: begin
        if (div_term_s) begin
          div_cnt_s = 8'd0;
          state_s   = ST_DONE;
          cs_n_s    = 1'b1;
          mosi_s    = 1'b0;
          stall_s   = 1'b0;
          done_s    = 1'b1;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_s   = ST_IDLE;
        bit_cnt_s = 9'd0;
      end
      default: begin
        state_s   = ST_IDLE;
        div_cnt_s = 8'd0;
        bit_cnt_s = 9'd0;
        sck_s     = 1'b0;
        cs_n_s    = 1'b1;
        mosi_s    = 1'b0;
        stall_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 9'd0;
      sck_r     <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      stall_r   <= 1'b0;
      done_r    <= 1'b0;
`ifdef DU_WR_CRC_EN
      crc_r     <= 8'h00;
`endif
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      div_cnt_r <= div_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      sck_r     <= sck_s;
      cs_n_r    <= cs_n_s;
      mosi_r    <= mosi_s;
      stall_r   <= stall_s;
      done_r    <= done_s;
`ifdef DU_WR_CRC_EN
      crc_r     <= crc_s;
`endif
    end
  end

  assign bus.du_wr_stall = stall_r;
  assign bus.du_wr_done  = done_r;
  assign bus.spi_cs_n    = cs_n_r;
  assign bus.spi_sck     = sck_r;
  assign bus.spi_mosi    = mosi_r;

endmodule

// File: tb/tb_dist_writeback_unit.sv
// Directed bench for dist_writeback_unit: an N=4 and an N=1 instance, a sampling SPI slave and a vector table.
module tb_dist_writeback_unit;

`ifdef DU_WR_CRC_EN
  localparam int CRC_W = 8;
  localparam int NBITS = 296;
  localparam int NUM_V = 4;
`else
  localparam int CRC_W = 0;
  localparam int NBITS = 288;
  localparam int NUM_V = 3;
`endif
  localparam int LIMIT = 6000;

  typedef struct {
    logic         s;
    logic [31:0]  rs1;
    logic [255:0] data;
    logic [7:0]   exp_cmd;
    logic [23:0]  exp_addr;
    logic [255:0] exp_data;
    int           exp_done;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         sel;
  logic [31:0]  rs1_v;
  logic [255:0] data_v;
  int           n_vec = 0;
  int           n_err = 0;
  vec_t         vt[NUM_V];

  logic cs_n_m, sck_m, mosi_m, stall_m, done_m;

  always #5 clk = ~clk;

  dist_writeback_unit_if b4();
  dist_writeback_unit_if b1();

  assign b4.DUWrCtrl = req & ~sel;
  assign b4.rs1      = rs1_v;
  assign b4.DU_data  = data_v;
  assign b1.DUWrCtrl = req & sel;
  assign b1.rs1      = rs1_v;
  assign b1.DU_data  = data_v;

  assign cs_n_m  = sel ? b1.spi_cs_n    : b4.spi_cs_n;
  assign sck_m   = sel ? b1.spi_sck     : b4.spi_sck;
  assign mosi_m  = sel ? b1.spi_mosi    : b4.spi_mosi;
  assign stall_m = sel ? b1.du_wr_stall : b4.du_wr_stall;
  assign done_m  = sel ? b1.du_wr_done  : b4.du_wr_done;

  dist_writeback_unit #(.CLK_DIV(4), .CMD_WRITE(8'h02)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  dist_writeback_unit #(.CLK_DIV(1), .CMD_WRITE(8'h02)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc8(input logic [287:0] msg);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 35; b >= 0; b--) begin
      c = c ^ msg[b*8 +: 8];
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Raise the request for one edge; that edge is E0 and we return sampling just after it.
  task automatic issue();
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // SPI slave: samples MOSI on SCK rise, checks edge timing, scrambles inputs after capture.
  task automatic monitor(input int repulse_at, input int hold_at, output logic [295:0] acc,
                         output int nbits, output int done_cyc, output int stall_cnt,
                         output int cs_cnt, output int terr, output logic done_after,
                         output logic [1:0] dflags);
    int n, cyc, falls;
    logic prev_sck;
    logic [31:0] a0;
    logic [255:0] d0;
    n = sel ? 1 : 4;
    acc = '0; nbits = 0; falls = 0; stall_cnt = 0; cs_cnt = 0; terr = 0;
    done_cyc = -1; cyc = 0; prev_sck = 1'b0; dflags = 2'b00;
    a0 = rs1_v; d0 = data_v;
    while (done_cyc < 0 && cyc < LIMIT) begin
      if (done_m) begin
        done_cyc = cyc;
        dflags = {cs_n_m, stall_m};
      end else begin
        if (stall_m) stall_cnt++;
        if (!cs_n_m) cs_cnt++;
      end
      if (sck_m && !prev_sck) begin
        if (cyc != n + 2*n*nbits) terr++;
        acc = {acc[294:0], mosi_m};
        nbits++;
      end
      if (!sck_m && prev_sck) begin
        falls++;
        if (cyc != 2*n*falls) terr++;
      end
      prev_sck = sck_m;
      if (cyc == 3) begin rs1_v = ~a0; data_v = ~d0; end
      if (cyc == 2000) begin rs1_v = a0; data_v = d0; end
      if (cyc == repulse_at) req = 1'b1;
      if (cyc == repulse_at + 1) req = 1'b0;
      if (cyc == hold_at) req = 1'b1;
      if (done_cyc < 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    @(posedge clk); #1;
    done_after = done_m;
  endtask

  task automatic check_frame(input string tag, input int vi, input logic [295:0] acc, input int nbits,
                             input int done_cyc, input int stall_cnt, input int cs_cnt, input int terr,
                             input logic done_after, input logic [1:0] dflags);
    logic [287:0] fr;
    fr = acc[CRC_W +: 288];
    check({tag, "_cmd"},   fr[287:280], vt[vi].exp_cmd);
    check({tag, "_addr"},  fr[279:256], vt[vi].exp_addr);
    check({tag, "_data"},  fr[255:0],   vt[vi].exp_data);
    check({tag, "_nbits"}, nbits,       NBITS);
    check({tag, "_done_cycle"}, done_cyc, vt[vi].exp_done);
    check({tag, "_stall_len"},  stall_cnt, vt[vi].exp_done);
    check({tag, "_cs_low_len"}, cs_cnt,    vt[vi].exp_done);
    check({tag, "_sck_timing_errs"}, terr, 0);
    check({tag, "_done_single"}, done_after, 1'b0);
    check({tag, "_done_cs_stall"}, dflags, 2'b10);
  endtask

  initial begin
    logic [295:0] acc;
    int nbits, dc, sc, cc, te, gap, bad, sck_seen;
    logic da;
    logic [1:0] df;

`ifdef DU_WR_CRC_EN
    vt[0] = '{1'b0, 32'hAB123456, 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF,
              8'h02, 24'h123456, 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF, 2372};
    vt[1] = '{1'b1, 32'h00FFEE01, {256{1'b1}}, 8'h02, 24'hFFEE01, {256{1'b1}}, 593};
    vt[2] = '{1'b0, 32'h5AA5A5A5, {1'b1, 254'h0, 1'b1}, 8'h02, 24'hA5A5A5, {1'b1, 254'h0, 1'b1}, 2372};
    vt[3] = '{1'b0, 32'h00000000, 256'h0, 8'h02, 24'h000000, 256'h0, 2372};
`else
    vt[0] = '{1'b0, 32'hAB123456, 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF,
              8'h02, 24'h123456, 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF, 2308};
    vt[1] = '{1'b1, 32'h00FFEE01, {256{1'b1}}, 8'h02, 24'hFFEE01, {256{1'b1}}, 577};
    vt[2] = '{1'b0, 32'h5AA5A5A5, {1'b1, 254'h0, 1'b1}, 8'h02, 24'hA5A5A5, {1'b1, 254'h0, 1'b1}, 2308};
`endif

    // Reset held while inputs toggle: both instances must sit at reset values.
    rst_n = 1'b0; req = 1'b0; sel = 1'b0; rs1_v = 32'h0; data_v = '0;
    bad = 0; sck_seen = 0;
    for (int i = 0; i < 8; i++) begin
      req = i[0];
      rs1_v = $urandom;
      data_v = {8{$urandom}};
      @(posedge clk); #1;
      if ({b4.spi_cs_n, b4.spi_sck, b4.spi_mosi, b4.du_wr_stall, b4.du_wr_done} !== 5'b10000) bad++;
      if ({b1.spi_cs_n, b1.spi_sck, b1.spi_mosi, b1.du_wr_stall, b1.du_wr_done} !== 5'b10000) bad++;
      if (b4.spi_sck || b1.spi_sck) sck_seen++;
    end
    check("reset_outputs_bad", bad, 0);
    check("reset_sck_high", sck_seen, 0);
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {cs_n_m, sck_m, mosi_m, stall_m, done_m}, 5'b10000);

    // Reset at E0+1000: outputs drop asynchronously and no done pulse follows.
    sel = 1'b0; rs1_v = vt[0].rs1; data_v = vt[0].data;
    issue();
    check("start_cs_stall_mosi", {cs_n_m, stall_m, mosi_m}, 3'b010);
    repeat (999) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {cs_n_m, sck_m, mosi_m, stall_m}, 4'b1000);
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_m) bad++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done_m) bad++;
    check("midreset_no_done", bad, 0);

    // Vector table: each frame captured by the bench slave and compared field by field.
    for (int v = 0; v < NUM_V; v++) begin
      sel = vt[v].s; rs1_v = vt[v].rs1; data_v = vt[v].data;
      @(posedge clk); #1;
      issue();
      monitor(-1, -1, acc, nbits, dc, sc, cc, te, da, df);
      check_frame($sformatf("v%0d", v), v, acc, nbits, dc, sc, cc, te, da, df);
`ifdef DU_WR_CRC_EN
      if (v == 3) check("v3_crc_byte", acc[7:0], ref_crc8({8'h02, 24'h000000, 256'h0}));
`endif
    end

    // Mid-frame re-pulse ignored; request held through DONE restarts after exactly 2 cs-high cycles.
    sel = 1'b0; rs1_v = vt[0].rs1; data_v = vt[0].data;
    @(posedge clk); #1;
    issue();
    monitor(100, 2300, acc, nbits, dc, sc, cc, te, da, df);
    check_frame("hold1", 0, acc, nbits, dc, sc, cc, te, da, df);
    gap = 1;
    while (cs_n_m && gap < 20) begin
      gap++;
      @(posedge clk); #1;
    end
    req = 1'b0;
    check("cs_high_gap", gap, 2);
    monitor(-1, -1, acc, nbits, dc, sc, cc, te, da, df);
    check_frame("hold2", 0, acc, nbits, dc, sc, cc, te, da, df);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
